// File: rtl/min_hour_counter_pkg.sv
// Shared definitions for the minute/hour counter: set-mode FSM encodings,
// the 2-bit state type and the minute terminal value.
package min_hour_counter_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_SET_MIN  = 2'b01;
  localparam logic [1:0] ST_SET_HOUR = 2'b10;

  localparam logic [7:0] MIN_MAX = 8'd59;

endpackage

// File: rtl/min_hour_counter_if.sv
// Control pulses in, time fields / FSM state / day carry out of the counter.
interface min_hour_counter_if;
  import min_hour_counter_pkg::*;

  logic       sec_rco;
  logic       en;
  logic       mode;
  logic       inc;
  logic [7:0] min_q;
  logic [7:0] hour_q;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  state_t     set_state;
  logic       drco;

  modport master (
    output sec_rco, en, mode, inc,
    input  min_q, hour_q, min_bcd, hour_bcd, set_state, drco
  );

  modport slave (
    input  sec_rco, en, mode, inc,
    output min_q, hour_q, min_bcd, hour_bcd, set_state, drco
  );

endinterface

// File: rtl/min_hour_counter_bin2bcd8.sv
// Binary (0..99) to two packed BCD digits, purely combinational.
module bin2bcd8 (
  input  logic [7:0] bin_i,
  output logic [7:0] bcd_o
);

  assign bcd_o = {4'(bin_i / 8'd10), 4'(bin_i % 8'd10)};

endmodule

// File: rtl/min_hour_counter.sv
// Minute/hour time-of-day counter with a RUN/SET_MIN/SET_HOUR editing FSM.
// Fields update on the msrco edge; BCD views are combinational; drco is a registered 1-cycle day carry.
module min_hour_counter
  import min_hour_counter_pkg::*;
#(
  parameter int unsigned HOUR_MAX = 23
) (
  input logic              msrco,
  input logic              clrn,
  min_hour_counter_if.slave bus
);

  localparam logic [7:0] HOUR_TOP = 8'(HOUR_MAX);

  state_t     state_q, state_d;
  logic [7:0] min_cnt_q, min_cnt_d;
  logic [7:0] hour_cnt_q, hour_cnt_d;
  logic       drco_q, drco_d;

  always_comb begin
    state_d    = state_q;
    min_cnt_d  = min_cnt_q;
    hour_cnt_d = hour_cnt_q;
    drco_d     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.en && bus.sec_rco) begin
          if (min_cnt_q >= MIN_MAX) begin
            min_cnt_d = '0;
            if (hour_cnt_q >= HOUR_TOP) begin
              hour_cnt_d = '0;
              drco_d     = 1'b1;
            end else begin
              hour_cnt_d = hour_cnt_q + 8'd1;
            end
          end else begin
            min_cnt_d = min_cnt_q + 8'd1;
          end
        end
        if (bus.mode) state_d = ST_SET_MIN;
      end
      ST_SET_MIN: begin
        // Editing never carries into the hour field.
        if (bus.inc) min_cnt_d = (min_cnt_q >= MIN_MAX) ? 8'd0 : min_cnt_q + 8'd1;
        if (bus.mode) state_d = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        if (bus.inc) hour_cnt_d = (hour_cnt_q >= HOUR_TOP) ? 8'd0 : hour_cnt_q + 8'd1;
        if (bus.mode) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge msrco or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_RUN;
      min_cnt_q  <= '0;
      hour_cnt_q <= '0;
      drco_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_cnt_q  <= min_cnt_d;
      hour_cnt_q <= hour_cnt_d;
      drco_q     <= drco_d;
    end
  end

  assign bus.min_q     = min_cnt_q;
  assign bus.hour_q    = hour_cnt_q;
  assign bus.set_state = state_q;
  assign bus.drco      = drco_q;

  bin2bcd8 u_min_bcd (
    .bin_i (min_cnt_q),
    .bcd_o (bus.min_bcd)
  );

  bin2bcd8 u_hour_bcd (
    .bin_i (hour_cnt_q),
    .bcd_o (bus.hour_bcd)
  );

endmodule
